rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
Shares the register file's single write port (RegWrite/WN/WD) between two writeback requesters: req0 (ALU writeback) and req1 (load return). Each requester has a one-entry holding slot. A round-robin arbiter drains one slot per cycle into a registered write-port output that drives the register file.
Read-after-pending-write hazard flags are produced for both read-port addresses so the core can stall until the write has landed.

Parameters:
ADDR_W, 5, register address width; register 0 is hardwired zero.
DATA_W, 32, write data width.
FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = req0 always wins.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
req0_valid  input  1  req0 presents a write.
req0_ready  output  1  req0 slot can accept this cycle.
req0_wn  input  ADDR_W  req0 destination register.
req0_wd  input  DATA_W  req0 write data.
req1_valid, req1_ready, req1_wn, req1_wd  same as req0, for requester 1.
RegWrite  output  1  register-file write enable (registered).
WN  output  ADDR_W  register-file write address (registered).
WD  output  DATA_W  register-file write data (registered).
RN1, RN2  input  ADDR_W  current read-port addresses from decode.
hazard1, hazard2  output  1  RN1 / RN2 has a write in flight.

Behaviour:
- Reset (sync, active-high), outputs and state:
  - Both slots empty; priority pointer = req0.
  - RegWrite=0, WN=0, WD=0.
  - req0_ready=req1_ready=0 while reset is high.
  - Any pending slot contents are discarded, including on a reset mid-operation.
- Handshake:
  - Transfer happens when valid && ready at a rising edge.
  - readyN = !reset && (slotN empty || slotN granted this cycle), so a requester can issue back-to-back writes.
- WN==0 requests:
  - Always accepted (ready rules above).
  - Slot is not loaded; the write is dropped and never reaches RegWrite.
- Arbitration (combinational, each cycle, over occupied slots):
  - Only one slot occupied: it is granted.
  - Both occupied, FIXED_PRIO=0: the pointer side wins; after the grant the pointer moves to the other requester.
  - Both occupied, FIXED_PRIO=1: req0 wins and the pointer is ignored.
  - Pointer changes only on a grant.
- Output register (every edge):
  - If a grant exists: RegWrite=1, WN/WD=granted slot; granted slot empties unless refilled the same edge.
  - No grant: RegWrite=0; WN/WD hold their previous values.
- Latency:
  - Request accepted at edge E0 appears on RegWrite/WN/WD after E1.
  - Register file updates at E2.
  - Minimum 2 edges from accept to file update; throughput 1 write/cycle aggregate.
- Ordering:
  - Per requester, writes commit in acceptance order.
  - Across requesters, grant order decides; the later-granted write to the same WN is final.
- Hazards:
  - hazardK = (RNK!=0) && RNK matches any occupied slot's wn or (RegWrite && WN).
  - Purely combinational; deasserts the cycle after the register file has taken the write.
- Simultaneous accept and grant on the same slot: the old entry goes to the output register and the new entry occupies the slot (no bubble).

Optional Feature:
RF_ARB_STATS_EN:
- When defined, adds outputs grant0_cnt[15:0], grant1_cnt[15:0] and conflict_cnt[15:0].
  - grantN_cnt counts grants to requester N.
  - conflict_cnt counts cycles in which both slots are occupied.
  - All three are saturating at 16'hFFFF and cleared by reset.
- When undefined, these ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Package rf_arb_pkg holds:
  - ADDR_W/DATA_W defaults.
  - Requester index constants REQ_ALU=0, REQ_LOAD=1.
  - A slot struct {valid, wn, wd}.
- Sub-module rf_wr_slot: one-entry holding register with valid/ready, a grant-pop input and a WN==0 drop. Instantiated twice.
- Arbitration, pointer, output register and hazard compare stay in the top module.

Test Plan:
- Reset, then req0 writes wn=5, wd=32'h1234 → RegWrite=1, WN=5, WD=32'h1234 exactly one cycle after accept; hazard1=1 for RN1=5 until the file write edge.
- req0 and req1 both valid every cycle, wn=1 and wn=2 respectively, FIXED_PRIO=0 → grants alternate req0, req1, req0…; each ready toggles accordingly; 8 writes complete in 8 cycles after fill.
- Same stimulus with FIXED_PRIO=1 → req0 granted every cycle; req1_ready stays 0 once its slot fills; req1 drains only after req0_valid drops.
- req1 writes wn=0, wd=32'hFFFF → accepted, RegWrite never asserts, hazard flags stay 0 for RN1=RN2=0.
- Both slots loaded (wn=7, wd=1 on req0 and wn=7, wd=2 on req1, pointer=req0), reset asserted the next cycle → no RegWrite pulse, slots empty, readies 0 during reset, RegWrite=0/WN=0/WD=0 after.
- With RF_ARB_STATS_EN defined: 3 conflict cycles and 5 total grants (3 req0, 2 req1) → conflict_cnt=3, grant0_cnt=3, grant1_cnt=2; forcing 70000 grants leaves the counter at 16'hFFFF.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rf_arb_pkg
// Shared definitions for the register-file write-port arbiter:
//   RF_ADDR_W / RF_DATA_W : default register address / data widths
//   REQ_ALU / REQ_LOAD    : requester indices (ALU writeback, load return)
//   rr_ptr_e              : round-robin pointer (which requester wins a tie)
//   rf_slot_t             : one holding-slot entry {valid, wn, wd}
//   sat_inc16             : saturating 16-bit increment for statistics
// ---------------------------------------------------------------------------
package rf_arb_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int NUM_REQ  = 2;

  typedef enum logic {
    PTR_ALU  = 1'b0,
    PTR_LOAD = 1'b1
  } rr_ptr_e;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] wn;
    logic [RF_DATA_W-1:0] wd;
  } rf_slot_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter_if
// One writeback requester channel (valid/ready handshake).
//   valid : requester presents a write
//   ready : arbiter slot can accept this cycle
//   wn    : destination register
//   wd    : write data
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface rf_write_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] wn;
  logic [DATA_W-1:0] wd;

  modport master (output valid, output wn, output wd, input ready);
  modport slave  (input valid, input wn, input wd, output ready);
endinterface

// File: rtl/rf_wr_slot.sv
// ---------------------------------------------------------------------------
// rf_wr_slot
// One-entry holding register in front of the write-port arbiter.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : requester handshake
//   in_wn/in_wd         : incoming write address / data
//   pop                 : arbiter grants this slot this cycle
//   slot                : current slot contents {valid, wn, wd}
// A write to register 0 is accepted but never stored. A pop and a new
// accept on the same edge replace the entry without a bubble.
// ---------------------------------------------------------------------------
module rf_wr_slot
  import rf_arb_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_wn,
  input  logic [DATA_W-1:0] in_wd,
  output logic              in_ready,
  input  logic              pop,
  output rf_slot_t          slot
);

  rf_slot_t slot_reg;
  rf_slot_t slot_next;
  logic     load;

  // Ready if empty, or if the current entry leaves this very cycle.
  assign in_ready = !reset && (!slot_reg.valid || pop);
  // Writes to r0 complete the handshake but are dropped here.
  assign load     = in_valid && in_ready && (in_wn != '0);

  always_comb begin
    slot_next = slot_reg;
    if (pop) begin
      slot_next.valid = 1'b0;
    end
    if (load) begin
      slot_next.valid = 1'b1;
      slot_next.wn    = in_wn;
      slot_next.wd    = in_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_reg <= '0;
    end else begin
      slot_reg <= slot_next;
    end
  end

  assign slot = slot_reg;

endmodule

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
// Shares the register file's single write port between the ALU writeback
// (req0) and the load return (req1). Each requester owns a one-entry slot;
// one occupied slot is granted per cycle into a registered write port.
//   clk, reset        : clock, synchronous active-high reset
//   req0, req1        : requester channels (rf_write_arbiter_if.slave)
//   RegWrite, WN, WD  : registered register-file write port
//   RN1, RN2          : read-port addresses from decode
//   hazard1, hazard2  : RN1/RN2 has a write still in flight
// Optional (macro RF_ARB_STATS_EN): grant0_cnt, grant1_cnt, conflict_cnt,
// 16-bit saturating counters cleared by reset.
// Parameter FIXED_PRIO: 0 = round-robin on conflict, 1 = req0 always wins.
// Slot storage uses rf_slot_t, so ADDR_W/DATA_W must equal the package widths.
// ---------------------------------------------------------------------------
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int DATA_W     = RF_DATA_W,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  rf_write_arbiter_if.slave req0,
  rf_write_arbiter_if.slave req1,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WN,
  output logic [DATA_W-1:0] WD,
  input  logic [ADDR_W-1:0] RN1,
  input  logic [ADDR_W-1:0] RN2,
  output logic              hazard1,
  output logic              hazard2
`ifdef RF_ARB_STATS_EN
  ,
  output logic [15:0]       grant0_cnt,
  output logic [15:0]       grant1_cnt,
  output logic [15:0]       conflict_cnt
`endif
);

  // Flatten the two channels so the slots can be generated uniformly.
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [ADDR_W-1:0]  req_wn [NUM_REQ];
  logic [DATA_W-1:0]  req_wd [NUM_REQ];

  assign req_valid[REQ_ALU]  = req0.valid;
  assign req_valid[REQ_LOAD] = req1.valid;
  assign req_wn[REQ_ALU]     = req0.wn;
  assign req_wn[REQ_LOAD]    = req1.wn;
  assign req_wd[REQ_ALU]     = req0.wd;
  assign req_wd[REQ_LOAD]    = req1.wd;
  assign req0.ready          = req_ready[REQ_ALU];
  assign req1.ready          = req_ready[REQ_LOAD];

  rf_slot_t           slot [NUM_REQ];
  logic [NUM_REQ-1:0] occ;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] hit1;
  logic [NUM_REQ-1:0] hit2;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      rf_wr_slot #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
      ) u_slot (
        .clk      (clk),
        .reset    (reset),
        .in_valid (req_valid[gi]),
        .in_wn    (req_wn[gi]),
        .in_wd    (req_wd[gi]),
        .in_ready (req_ready[gi]),
        .pop      (grant[gi]),
        .slot     (slot[gi])
      );

      assign occ[gi]  = slot[gi].valid;
      assign hit1[gi] = slot[gi].valid && (slot[gi].wn == RN1);
      assign hit2[gi] = slot[gi].valid && (slot[gi].wn == RN2);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Arbitration and round-robin pointer
  // -------------------------------------------------------------------------
  rr_ptr_e ptr_reg;
  rr_ptr_e ptr_next;

  always_comb begin
    grant = '0;
    if (occ[REQ_ALU] && occ[REQ_LOAD]) begin
      if ((FIXED_PRIO != 0) || (ptr_reg == PTR_ALU)) begin
        grant[REQ_ALU] = 1'b1;
      end else begin
        grant[REQ_LOAD] = 1'b1;
      end
    end else begin
      grant = occ;
    end
  end

  // The pointer hands the next tie to whoever did not just win; it only
  // moves on a grant so an idle cycle keeps the fairness state.
  always_comb begin
    ptr_next = ptr_reg;
    if (grant[REQ_ALU]) begin
      ptr_next = PTR_LOAD;
    end else if (grant[REQ_LOAD]) begin
      ptr_next = PTR_ALU;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= PTR_ALU;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  // -------------------------------------------------------------------------
  // Registered write port
  // -------------------------------------------------------------------------
  logic              regwrite_reg, regwrite_next;
  logic [ADDR_W-1:0] wn_reg, wn_next;
  logic [DATA_W-1:0] wd_reg, wd_next;

  always_comb begin
    regwrite_next = |grant;
    wn_next       = wn_reg;   // address/data hold when idle
    wd_next       = wd_reg;
    if (grant[REQ_ALU]) begin
      wn_next = slot[REQ_ALU].wn;
      wd_next = slot[REQ_ALU].wd;
    end else if (grant[REQ_LOAD]) begin
      wn_next = slot[REQ_LOAD].wn;
      wd_next = slot[REQ_LOAD].wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_reg <= 1'b0;
      wn_reg       <= '0;
      wd_reg       <= '0;
    end else begin
      regwrite_reg <= regwrite_next;
      wn_reg       <= wn_next;
      wd_reg       <= wd_next;
    end
  end

  assign RegWrite = regwrite_reg;
  assign WN       = wn_reg;
  assign WD       = wd_reg;

  // -------------------------------------------------------------------------
  // Hazards: a write is in flight while it sits in a slot or in the output
  // register; r0 never hazards since its writes are discarded.
  // -------------------------------------------------------------------------
  assign hazard1 = (RN1 != '0) && ((|hit1) || (regwrite_reg && (wn_reg == RN1)));
  assign hazard2 = (RN2 != '0) && ((|hit2) || (regwrite_reg && (wn_reg == RN2)));

`ifdef RF_ARB_STATS_EN
  // -------------------------------------------------------------------------
  // Statistics
  // -------------------------------------------------------------------------
  logic [15:0] grant0_cnt_reg, grant1_cnt_reg, conflict_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      grant0_cnt_reg   <= '0;
      grant1_cnt_reg   <= '0;
      conflict_cnt_reg <= '0;
    end else begin
      if (grant[REQ_ALU]) begin
        grant0_cnt_reg <= sat_inc16(grant0_cnt_reg);
      end
      if (grant[REQ_LOAD]) begin
        grant1_cnt_reg <= sat_inc16(grant1_cnt_reg);
      end
      if (&occ) begin
        conflict_cnt_reg <= sat_inc16(conflict_cnt_reg);
      end
    end
  end

  assign grant0_cnt   = grant0_cnt_reg;
  assign grant1_cnt   = grant1_cnt_reg;
  assign conflict_cnt = conflict_cnt_reg;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_write_arbiter
// Drives two arbiters (round-robin and fixed-priority) with identical
// stimulus and compares every cycle against a transaction-level model:
// per-requester one-entry slots, a winner picked by the arbitration rules,
// and the write port / hazard / statistics values those rules imply.
// ---------------------------------------------------------------------------
module tb_rf_write_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus shared by both instances
  logic        rst;
  logic        v   [2];
  logic [4:0]  wn  [2];
  logic [31:0] wd  [2];
  logic [4:0]  rn1, rn2;

  rf_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) rq0_a ();
  rf_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) rq1_a ();
  rf_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) rq0_b ();
  rf_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) rq1_b ();

  assign rq0_a.valid = v[0];  assign rq0_a.wn = wn[0];  assign rq0_a.wd = wd[0];
  assign rq1_a.valid = v[1];  assign rq1_a.wn = wn[1];  assign rq1_a.wd = wd[1];
  assign rq0_b.valid = v[0];  assign rq0_b.wn = wn[0];  assign rq0_b.wd = wd[0];
  assign rq1_b.valid = v[1];  assign rq1_b.wn = wn[1];  assign rq1_b.wd = wd[1];

  // Observed outputs, index 0 = round-robin, 1 = fixed priority
  logic [1:0]  o_rw, o_h1, o_h2, o_rdy0, o_rdy1;
  logic [4:0]  o_wn [2];
  logic [31:0] o_wd [2];
  assign o_rdy0[0] = rq0_a.ready;  assign o_rdy1[0] = rq1_a.ready;
  assign o_rdy0[1] = rq0_b.ready;  assign o_rdy1[1] = rq1_b.ready;
`ifdef RF_ARB_STATS_EN
  logic [15:0] o_g0 [2];
  logic [15:0] o_g1 [2];
  logic [15:0] o_cf [2];
`endif

  rf_write_arbiter #(.ADDR_W(5), .DATA_W(32), .FIXED_PRIO(0)) dut_rr (
    .clk      (clk),
    .reset    (rst),
    .req0     (rq0_a),
    .req1     (rq1_a),
    .RegWrite (o_rw[0]),
    .WN       (o_wn[0]),
    .WD       (o_wd[0]),
    .RN1      (rn1),
    .RN2      (rn2),
    .hazard1  (o_h1[0]),
    .hazard2  (o_h2[0])
`ifdef RF_ARB_STATS_EN
    ,
    .grant0_cnt   (o_g0[0]),
    .grant1_cnt   (o_g1[0]),
    .conflict_cnt (o_cf[0])
`endif
  );

  rf_write_arbiter #(.ADDR_W(5), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
    .clk      (clk),
    .reset    (rst),
    .req0     (rq0_b),
    .req1     (rq1_b),
    .RegWrite (o_rw[1]),
    .WN       (o_wn[1]),
    .WD       (o_wd[1]),
    .RN1      (rn1),
    .RN2      (rn2),
    .hazard1  (o_h1[1]),
    .hazard2  (o_h2[1])
`ifdef RF_ARB_STATS_EN
    ,
    .grant0_cnt   (o_g0[1]),
    .grant1_cnt   (o_g1[1]),
    .conflict_cnt (o_cf[1])
`endif
  );

  // ------------------------------------------------------------------------
  // Reference model (index [inst][requester])
  // ------------------------------------------------------------------------
  bit          m_occ [2][2];
  logic [4:0]  m_swn [2][2];
  logic [31:0] m_swd [2][2];
  int          m_ptr [2];          // requester that wins the next tie
  bit          m_rw  [2];
  logic [4:0]  m_wno [2];
  logic [31:0] m_wdo [2];
  int          m_g0 [2], m_g1 [2], m_cf [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst%0d cyc%0d observed=%h expected=%h", tag, i, cyc, obs, exp);
    end
  endtask

  function automatic int winner(input int i);
    if (m_occ[i][0] && m_occ[i][1]) return (i == 1) ? 0 : m_ptr[i];
    if (m_occ[i][0]) return 0;
    if (m_occ[i][1]) return 1;
    return -1;
  endfunction

  function automatic bit hz(input int i, input logic [4:0] rn);
    if (rn == 5'd0) return 1'b0;
    return (m_occ[i][0] && m_swn[i][0] == rn) || (m_occ[i][1] && m_swn[i][1] == rn) ||
           (m_rw[i] && m_wno[i] == rn);
  endfunction

  function automatic int sat(input int x);
    return (x >= 65535) ? 65535 : x + 1;
  endfunction

  // One clock cycle: check at the falling edge, then advance the model by
  // what the coming rising edge must do.
  task automatic cycle(input bit chk_en);
    int w;
    bit rdy [2];
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      w = winner(i);
      for (int r = 0; r < 2; r++) rdy[r] = !rst && (!m_occ[i][r] || w == r);
      if (chk_en) begin
        chk("ready0",   i, {31'd0, o_rdy0[i]}, {31'd0, rdy[0]});
        chk("ready1",   i, {31'd0, o_rdy1[i]}, {31'd0, rdy[1]});
        chk("hazard1",  i, {31'd0, o_h1[i]},   {31'd0, hz(i, rn1)});
        chk("hazard2",  i, {31'd0, o_h2[i]},   {31'd0, hz(i, rn2)});
        chk("RegWrite", i, {31'd0, o_rw[i]},   {31'd0, m_rw[i]});
        chk("WN",       i, {27'd0, o_wn[i]},   {27'd0, m_wno[i]});
        chk("WD",       i, o_wd[i],            m_wdo[i]);
`ifdef RF_ARB_STATS_EN
        chk("grant0_cnt",   i, {16'd0, o_g0[i]}, m_g0[i]);
        chk("grant1_cnt",   i, {16'd0, o_g1[i]}, m_g1[i]);
        chk("conflict_cnt", i, {16'd0, o_cf[i]}, m_cf[i]);
`endif
      end
      if (rst) begin
        m_occ[i][0] = 0; m_occ[i][1] = 0; m_ptr[i] = 0;
        m_rw[i] = 0; m_wno[i] = '0; m_wdo[i] = '0;
        m_g0[i] = 0; m_g1[i] = 0; m_cf[i] = 0;
      end else begin
        if (m_occ[i][0] && m_occ[i][1]) m_cf[i] = sat(m_cf[i]);
        if (w >= 0) begin
          m_rw[i] = 1; m_wno[i] = m_swn[i][w]; m_wdo[i] = m_swd[i][w];
          m_occ[i][w] = 0; m_ptr[i] = 1 - w;
          if (w == 0) m_g0[i] = sat(m_g0[i]); else m_g1[i] = sat(m_g1[i]);
        end else begin
          m_rw[i] = 0;
        end
        for (int r = 0; r < 2; r++) begin
          if (v[r] && rdy[r] && wn[r] != 5'd0) begin
            m_occ[i][r] = 1; m_swn[i][r] = wn[r]; m_swd[i][r] = wd[r];
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    v[0] = 0; v[1] = 0;
  endtask

  int pulses;

  initial begin
    rst = 1; v[0] = 0; v[1] = 0; wn[0] = 0; wn[1] = 0; wd[0] = 0; wd[1] = 0;
    rn1 = 0; rn2 = 0;
    for (int i = 0; i < 2; i++) begin
      m_occ[i][0] = 0; m_occ[i][1] = 0; m_ptr[i] = 0; m_rw[i] = 0;
      m_wno[i] = 0; m_wdo[i] = 0; m_g0[i] = 0; m_g1[i] = 0; m_cf[i] = 0;
      m_swn[i][0] = 0; m_swn[i][1] = 0; m_swd[i][0] = 0; m_swd[i][1] = 0;
    end

    // Reset: first edges settle the DUT, then check the held-in-reset state
    cycle(0); cycle(0);
    v[0] = 1; v[1] = 1; wn[0] = 3; wn[1] = 4;   // readies must still be 0
    cycle(1);
    idle(); rst = 0;
    cycle(1);

    // Single req0 write wn=5 with a hazard watch on RN1
    rn1 = 5; v[0] = 1; wn[0] = 5; wd[0] = 32'h1234;
    cycle(1);
    idle();
    for (int k = 0; k < 4; k++) cycle(1);

    // Both requesters streaming: wn=1 on req0, wn=2 on req1
    rn1 = 1; rn2 = 2; pulses = 0;
    for (int k = 0; k < 10; k++) begin
      v[0] = 1; v[1] = 1; wn[0] = 1; wn[1] = 2;
      wd[0] = 32'hA000_0000 + k; wd[1] = 32'hB000_0000 + k;
      cycle(1);
      if (k >= 1 && k <= 8) pulses += int'(o_rw[0]);
    end
    chk("rr_throughput", 0, pulses, 8);
    // req0 drops: fixed-priority instance drains req1
    idle();
    for (int k = 0; k < 4; k++) cycle(1);

    // req1 writes r0: accepted, never written, never hazards
    rn1 = 0; rn2 = 0; v[1] = 1; wn[1] = 0; wd[1] = 32'hFFFF;
    cycle(1);
    idle();
    for (int k = 0; k < 3; k++) cycle(1);

    // Reset mid-operation with both slots loaded (wn=7)
    rst = 1; cycle(1); rst = 0; cycle(1);
    rn1 = 7; v[0] = 1; v[1] = 1; wn[0] = 7; wn[1] = 7; wd[0] = 1; wd[1] = 2;
    cycle(1);
    idle(); rst = 1;
    cycle(1);
    rst = 0;
    for (int k = 0; k < 3; k++) cycle(1);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      rst   = ($urandom_range(0, 63) == 0);
      v[0]  = $urandom_range(0, 1);
      v[1]  = $urandom_range(0, 1);
      wn[0] = 5'($urandom_range(0, 7));
      wn[1] = 5'($urandom_range(0, 7));
      wd[0] = $urandom;
      wd[1] = $urandom;
      rn1   = 5'($urandom_range(0, 7));
      rn2   = 5'($urandom_range(0, 7));
      cycle(1);
    end
    rst = 0; idle();
    cycle(1);

`ifdef RF_ARB_STATS_EN
    // Directed statistics: 3 conflict cycles, grants 3/2 on round-robin
    rst = 1; cycle(1); rst = 0;
    for (int k = 0; k < 3; k++) begin
      v[0] = 1; v[1] = 1; wn[0] = 1; wn[1] = 2; cycle(1);
    end
    idle(); cycle(1); cycle(1);
    v[0] = 1; wn[0] = 3; cycle(1);
    idle(); for (int k = 0; k < 3; k++) cycle(1);
    chk("stat_rr_g0", 0, {16'd0, o_g0[0]}, 3);
    chk("stat_rr_g1", 0, {16'd0, o_g1[0]}, 2);
    chk("stat_rr_cf", 0, {16'd0, o_cf[0]}, 3);
    chk("stat_fp_g0", 1, {16'd0, o_g0[1]}, 4);
    chk("stat_fp_g1", 1, {16'd0, o_g1[1]}, 1);
    chk("stat_fp_cf", 1, {16'd0, o_cf[1]}, 3);
    // Saturation: 70000 consecutive grants
    v[0] = 1; wn[0] = 1;
    for (int k = 0; k < 70000; k++) cycle(0);
    idle(); cycle(1);
    chk("stat_sat_g0", 0, {16'd0, o_g0[0]}, 32'h0000_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
